// File: rtl/uart_tx_scheduler_if.sv
// Requester and UART-side signals of the tx scheduler, bundled as one interface.
// The scheduler uses the master modport; the requesters, UART byte transmitter,
// tx mux and j1 core see the slave side.
interface uart_tx_scheduler_if;
  // Command channel (ch0)
  logic       ch0_valid;
  logic [7:0] ch0_byte;
  logic       ch0_last;
  logic       ch0_ready;
  // Data channel (ch1)
  logic       ch1_valid;
  logic [7:0] ch1_byte;
  logic       ch1_last;
  logic       ch1_ready;
  // UART byte transmitter handshake
  logic       uart_start;
  logic [7:0] uart_byte;
  logic       uart_busy;
  // Mux select, core-visible busy flag, sticky error
  logic       sel;
  logic       bussy;
  logic       err_timeout;

  modport master (
    input  ch0_valid, ch0_byte, ch0_last,
    output ch0_ready,
    input  ch1_valid, ch1_byte, ch1_last,
    output ch1_ready,
    output uart_start, uart_byte,
    input  uart_busy,
    output sel, bussy, err_timeout
  );

  modport slave (
    output ch0_valid, ch0_byte, ch0_last,
    input  ch0_ready,
    output ch1_valid, ch1_byte, ch1_last,
    input  ch1_ready,
    input  uart_start, uart_byte,
    output uart_busy,
    input  sel, bussy, err_timeout
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Frame-level round-robin scheduler for the shared UART tx line. Grants whole
// frames to the command (ch0) or data (ch1) requester and feeds their bytes one
// at a time to the UART byte transmitter over a start/busy handshake.
module uart_tx_scheduler #(
  parameter int GAP_CYCLES  = 16,   // idle cycles forced between frames, 0 = none
  parameter int ACK_TIMEOUT = 255,  // max cycles from start for uart_busy to rise
  parameter int CNT_W       = 8     // must hold max(GAP_CYCLES, ACK_TIMEOUT)
) (
  input logic                  clk,
  input logic                  rst,   // asynchronous, active low
  uart_tx_scheduler_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  localparam bit             HAS_GAP   = (GAP_CYCLES > 0);
  localparam logic [CNT_W-1:0] ACK_LIMIT = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic             sel_q, sel_nx;
  logic             last_grant, last_grant_nx;
  logic             last_flag, last_flag_nx;
  logic [7:0]       byte_q, byte_nx;
  logic             err_q, err_nx;
  logic             grant;

  // Granted channel's byte stream; sel_q is the frame owner from grant onward.
  logic       acc_valid;
  logic [7:0] acc_byte;
  logic       acc_last;

  assign acc_valid = sel_q ? bus.ch1_valid : bus.ch0_valid;
  assign acc_byte  = sel_q ? bus.ch1_byte  : bus.ch0_byte;
  assign acc_last  = sel_q ? bus.ch1_last  : bus.ch0_last;
  assign cnt_inc   = cnt + CNT_W'(1);

  // State and datapath registers; reset drops any frame and re-arms ch0 priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sel_q      <= 1'b0;
      last_grant <= 1'b1;
      last_flag  <= 1'b0;
      byte_q     <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_nx;
      cnt        <= cnt_nx;
      sel_q      <= sel_nx;
      last_grant <= last_grant_nx;
      last_flag  <= last_flag_nx;
      byte_q     <= byte_nx;
      err_q      <= err_nx;
    end
  end

  // Next-state logic: arbitration, byte hand-off, ack timeout and inter-frame gap.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path can infer a latch.
    state_nx      = state;
    cnt_nx        = cnt;
    sel_nx        = sel_q;
    last_grant_nx = last_grant;
    last_flag_nx  = last_flag;
    byte_nx       = byte_q;
    err_nx        = err_q;
    grant         = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (bus.ch0_valid || bus.ch1_valid) begin
          if (bus.ch0_valid && bus.ch1_valid) grant = ~last_grant;
          else                                grant = bus.ch1_valid;
          sel_nx        = grant;
          last_grant_nx = grant;
          state_nx      = S_LOAD;
        end
      end

      S_LOAD: begin
        if (acc_valid) begin
          byte_nx      = acc_byte;
          last_flag_nx = acc_last;
          state_nx     = S_START;
        end
      end

      S_START: begin
        cnt_nx   = '0;
        state_nx = S_WAIT_ACK;
      end

      S_WAIT_ACK: begin
        if (bus.uart_busy) begin
          state_nx = S_WAIT_DONE;
        end else if (cnt_inc == ACK_LIMIT) begin
          // Transmitter never answered: abandon the rest of this frame.
          err_nx   = 1'b1;
          cnt_nx   = '0;
          state_nx = HAS_GAP ? S_GAP : S_IDLE;
        end else begin
          cnt_nx = cnt_inc;
        end
      end

      S_WAIT_DONE: begin
        if (!bus.uart_busy) begin
          cnt_nx = '0;
          if (!last_flag)   state_nx = S_LOAD;
          else if (HAS_GAP) state_nx = S_GAP;
          else              state_nx = S_IDLE;
        end
      end

      S_GAP: begin
        if (cnt == GAP_LAST) state_nx = S_IDLE;
        else                 cnt_nx   = cnt_inc;
      end

      default: state_nx = S_IDLE;
    endcase
  end

  // Ready is combinational on the granted channel only, so acceptance costs no cycle.
  assign bus.ch0_ready   = (state == S_LOAD) && !sel_q && bus.ch0_valid;
  assign bus.ch1_ready   = (state == S_LOAD) &&  sel_q && bus.ch1_valid;
  assign bus.uart_start  = (state == S_START);
  assign bus.uart_byte   = byte_q;
  assign bus.sel         = sel_q;
  assign bus.bussy       = (state != S_IDLE);
  assign bus.err_timeout = err_q;

endmodule
